// File: rtl/tx_fifo_mutex_arb.sv
// Port-ownership arbiter and write multiplexer for the PHY-TX FIFOs.
// Grants whole port masks atomically, round-robin, and forwards only each owner's writes.
module tx_fifo_mutex_arb #(
  parameter int unsigned NREQ  = 5,
  parameter int unsigned NPORT = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [NREQ*NPORT-1:0] req_mask,
  output logic [NREQ*NPORT-1:0] grant,
  input  logic [NREQ*8-1:0]     req_din,
  input  logic [NREQ-1:0]       req_del,
  input  logic [NREQ*NPORT-1:0] req_wren,
  output logic [NPORT*8-1:0]    fifo_din,
  output logic [NPORT-1:0]      fifo_del,
  output logic [NPORT-1:0]      fifo_wren,
  output logic                  wr_violation
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MW = NREQ * NPORT;

  logic [NPORT-1:0]          busy_q, busy_d;
  logic [NPORT-1:0][OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [MW-1:0]             grant_q, grant_d;
  logic [NPORT*8-1:0]        fifo_din_q, fifo_din_d;
  logic [NPORT-1:0]          fifo_del_q, fifo_del_d;
  logic [NPORT-1:0]          fifo_wren_q, fifo_wren_d;
  logic                      wr_violation_q, wr_violation_d;

  logic [MW-1:0]             own_c;
  logic [NREQ-1:0]           holds_c;
  logic [NPORT-1:0]          keep_c;

  // Who owns what right now; a port whose owner dropped its mask bit is not kept.
  always_comb begin : own_view
    own_c   = '0;
    holds_c = '0;
    keep_c  = '0;
    for (int r = 0; r < int'(NREQ); r++) begin
      for (int p = 0; p < int'(NPORT); p++) begin
        if (busy_q[p] && (owner_q[p] == OW'(r))) begin
          holds_c[r]          = 1'b1;
          own_c[r*NPORT + p]  = req_mask[r*NPORT + p];
          keep_c[p]           = req_mask[r*NPORT + p];
        end
      end
    end
  end

  // Round-robin search from rr_ptr; eligibility is judged on pre-release state.
  always_comb begin : arb
    logic             found;
    int               win;
    int               idx;
    logic [NPORT-1:0] m;
    busy_d   = keep_c;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = '0;
    found    = 1'b0;
    win      = 0;
    idx      = 0;
    m        = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = (int'(rr_ptr_q) + i) % int'(NREQ);
      m   = req_mask[idx*NPORT +: NPORT];
      if (!found && (m != '0) && !holds_c[idx] && ((m & busy_q) == '0)) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      for (int p = 0; p < int'(NPORT); p++) begin
        if (req_mask[win*NPORT + p]) begin
          busy_d[p]  = 1'b1;
          owner_d[p] = OW'(win);
        end
      end
      rr_ptr_d = (win == int'(NREQ) - 1) ? '0 : OW'(win + 1);
    end
    for (int r = 0; r < int'(NREQ); r++) begin
      for (int p = 0; p < int'(NPORT); p++) begin
        grant_d[r*NPORT + p] = busy_d[p] && (owner_d[p] == OW'(r));
      end
    end
  end

  // Owner's byte stream per port; writes from non-owners are dropped and flagged.
  always_comb begin : datapath
    fifo_din_d     = '0;
    fifo_del_d     = '0;
    fifo_wren_d    = '0;
    wr_violation_d = |(req_wren & ~own_c);
    for (int p = 0; p < int'(NPORT); p++) begin
      for (int r = 0; r < int'(NREQ); r++) begin
        if (busy_q[p] && (owner_q[p] == OW'(r))) begin
          fifo_din_d[p*8 +: 8] = req_din[r*8 +: 8];
          fifo_del_d[p]        = req_del[r];
        end
        fifo_wren_d[p] = fifo_wren_d[p] | (own_c[r*NPORT + p] & req_wren[r*NPORT + p]);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q         <= '0;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      fifo_din_q     <= '0;
      fifo_del_q     <= '0;
      fifo_wren_q    <= '0;
      wr_violation_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      fifo_din_q     <= fifo_din_d;
      fifo_del_q     <= fifo_del_d;
      fifo_wren_q    <= fifo_wren_d;
      wr_violation_q <= wr_violation_d;
    end
  end

  assign grant        = grant_q;
  assign fifo_din     = fifo_din_q;
  assign fifo_del     = fifo_del_q;
  assign fifo_wren    = fifo_wren_q;
  assign wr_violation = wr_violation_q;

endmodule
